neuron_sequencer: RTL
=====================

Name: neuron_sequencer

Overview:
- Drives the operand side of the combinational 8-input neuron datapath, which computes sum(x_i*w_i)+bias followed by ReLU.
- Accepts one frame of 8 signed 8-bit activations over a valid/ready stream.
- For each of NUM_NEURONS neurons, fetches 8 weights and 1 bias from a synchronous weight memory, presents them with the held activations to one shared neuron instance, and captures out_val.
- Emits one result byte per neuron on a valid/ready output stream. Sits between the input/activation source and the next layer.

Parameters:
- NUM_NEURONS, 4, neurons evaluated per frame (1..32).
- ADDR_W, 8, weight-memory address width; must satisfy 9*NUM_NEURONS <= 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  activation byte valid.
- in_ready  out  1  sequencer can accept activation.
- in_data  in  8  signed activation.
- wmem_en  out  1  weight-memory read enable.
- wmem_addr  out  ADDR_W  read address: neuron*9 + k; k=0..7 weights, k=8 bias.
- wmem_data  in  8  read data, valid the cycle after wmem_en.
- nx_flat  out  64  activations to neuron; x1 in [7:0] ... x8 in [63:56].
- nw_flat  out  64  weights to neuron, same packing.
- nbias  out  8  bias to neuron.
- nout  in  8  neuron out_val (combinational from nx/nw/nbias).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  8  ReLU result.
- out_last  out  1  marks result of neuron NUM_NEURONS-1.
- busy  out  1  high in any state except LOAD_X.

Behaviour:
- Reset (async, rst_n=0) forces:
  - State LOAD_X; all counters 0.
  - in_ready=1; out_valid=0, out_last=0, out_data=0, wmem_en=0, wmem_addr=0, busy=0.
  - nx_flat, nw_flat and nbias all 0.
- Reset mid-frame discards all partial data. No output is emitted for the aborted frame.
- LOAD_X:
  - in_ready=1. Each in_valid&in_ready edge stores in_data into slot x_cnt and increments x_cnt.
  - On the 8th accept, go to FETCH with neuron index n=0.
- FETCH:
  - in_ready=0. Issue 9 consecutive reads, addresses n*9+0 .. n*9+8, with wmem_en=1 for exactly 9 cycles.
  - Each wmem_data is captured one cycle after its read and stored into w slot k, or into bias for k=8.
  - After the bias is captured, go to EVAL.
- EVAL (1 cycle):
  - nx/nw/nbias registers are stable. At the edge, nout is registered into out_data, out_valid=1, and out_last=(n==NUM_NEURONS-1).
  - Next state is SEND.
- SEND:
  - out_valid, out_data and out_last hold stable until out_ready.
  - On handshake: if n < NUM_NEURONS-1, increment n and go to FETCH; otherwise go to LOAD_X with x_cnt=0.
- Latency:
  - out_valid rises exactly 11 rising edges after the edge accepting the 8th activation.
  - Each subsequent out_valid rises exactly 11 edges after the previous out handshake.
- Neuron inputs stay constant outside FETCH. Activations are held for the whole frame.
- out_ready high before out_valid has no effect. out_ready held constantly high gives a back-to-back handshake on the same edge out_valid is seen.
- in_valid is ignored whenever in_ready=0. Bytes are not dropped and not buffered.
- wmem_addr never exceeds 9*NUM_NEURONS-1. The address resets to 0 on return to LOAD_X.

Optional Feature:
- Macro NEURON_SEQ_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt (16-bit), reset 0.
  - Increments on the out handshake with out_last=1 and wraps from 0xFFFF to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package nn_pkg holds:
  - NUM_IN=8 and WORDS_PER_NEURON=9.
  - Data-width constant DATA_W=8.
  - State enum {LOAD_X, FETCH, EVAL, SEND}.
- One natural sub-module, nn_weight_fetch:
  - Handles address generation, the 1-cycle read-latency pipeline and capture into the w/bias registers.
  - Signals done to the parent FSM.

Test Plan:
- x=1..8, weights all 1, bias 0, NUM_NEURONS=1 -> out_data=0x24 (36), out_last=1, out_valid exactly 11 edges after the 8th accept.
- Same x, bias=0xC0 (-64) -> pre-activation -28 -> out_data=0x00.
- NUM_NEURONS=4, biases 0,1,2,3, weights all 0 -> outputs 0,1,2,3 in order; out_last only on the 4th; wmem_addr sequence 0..35 with no gaps.
- out_ready held low 20 cycles in SEND -> out_data stable, in_ready=0, no new reads issued.
- rst_n pulsed low after 5 activations or mid-FETCH -> all outputs at reset values immediately; next full frame produces correct results.
- With NEURON_SEQ_FRAME_CNT_EN, 3 frames of 4 neurons -> frame_cnt=3; preload 0xFFFF then one frame -> 0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the neuron sequencer.
package nn_pkg;

    localparam int NUM_IN           = 8;
    localparam int WORDS_PER_NEURON = 9;
    localparam int DATA_W           = 8;

    typedef enum logic [1:0] {
        LOAD_X,
        FETCH,
        EVAL,
        SEND
    } state_t;

endpackage

// File: rtl/nn_weight_fetch.sv
// Weight fetch engine: issues 9 consecutive reads (8 weights + bias),
// tracks the 1-cycle memory read latency and captures returned words into
// the weight/bias registers that feed the neuron datapath.
module nn_weight_fetch
    import nn_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          start_addr,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          wmem_data,
    output logic                       wmem_en,
    output logic [ADDR_W-1:0]          wmem_addr,
    output logic [NUM_IN*DATA_W-1:0]   w_flat,
    output logic [DATA_W-1:0]          bias,
    output logic                       done
);

    localparam logic [3:0] LAST_K = 4'(WORDS_PER_NEURON - 1);

    logic [3:0] rd_k;     // index of the read being issued
    logic       cap_vld;  // read data is on wmem_data this cycle
    logic [3:0] cap_k;    // index of the word on wmem_data

    // Bias is the final word of the burst; the parent leaves FETCH on the edge it lands.
    assign done = cap_vld && (cap_k == LAST_K);

    // Read issue, latency pipeline and capture into the operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wmem_en   <= 1'b0;
            wmem_addr <= '0;
            rd_k      <= '0;
            cap_vld   <= 1'b0;
            cap_k     <= '0;
            w_flat    <= '0;
            bias      <= '0;
        end else begin
            // NOTE: non-blocking assignments let cap_vld/cap_k sample the
            // pre-edge wmem_en/rd_k, which is exactly the 1-cycle read delay.
            cap_vld <= wmem_en;
            cap_k   <= rd_k;

            if (clear) begin
                wmem_en   <= 1'b0;
                wmem_addr <= '0;
                rd_k      <= '0;
            end else if (start) begin
                wmem_en   <= 1'b1;
                wmem_addr <= start_addr;
                rd_k      <= '0;
            end else if (wmem_en) begin
                rd_k <= rd_k + 4'd1;
                if (rd_k == LAST_K) begin
                    wmem_en <= 1'b0;  // address parks on the bias word
                end else begin
                    wmem_addr <= wmem_addr + 1'b1;
                end
            end

            if (cap_vld) begin
                if (cap_k == LAST_K) begin
                    bias <= wmem_data;
                end else begin
                    w_flat[{cap_k[2:0], 3'b000} +: DATA_W] <= wmem_data;
                end
            end
        end
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Neuron sequencer: loads 8 activations, then for each neuron fetches
// weights/bias, evaluates the shared combinational neuron and streams out
// one ReLU result per neuron.
// Optional macro NEURON_SEQ_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module neuron_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     wmem_en,
    output logic [ADDR_W-1:0]        wmem_addr,
    input  logic [DATA_W-1:0]        wmem_data,
    output logic [NUM_IN*DATA_W-1:0] nx_flat,
    output logic [NUM_IN*DATA_W-1:0] nw_flat,
    output logic [DATA_W-1:0]        nbias,
    input  logic [DATA_W-1:0]        nout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     busy
`ifdef NEURON_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0]              frame_cnt
`endif
);

    localparam int N_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    state_t              state;
    logic [2:0]          x_cnt;
    logic [N_W-1:0]      n;
    logic                in_fire;
    logic                out_fire;
    logic                last_n;
    logic                fetch_start;
    logic                fetch_clear;
    logic                fetch_done;
    logic [ADDR_W-1:0]   start_addr;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_n   = (n == N_W'(NUM_NEURONS - 1));

    // Fetch control: start a burst on the 8th accept or a non-final handshake,
    // park the address at 0 when the frame completes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        fetch_start = 1'b0;
        fetch_clear = 1'b0;
        start_addr  = '0;
        if (state == LOAD_X && in_fire && x_cnt == 3'd7) begin
            fetch_start = 1'b1;
        end
        if (state == SEND && out_fire) begin
            if (last_n) begin
                fetch_clear = 1'b1;
            end else begin
                fetch_start = 1'b1;
                start_addr  = ADDR_W'((int'(n) + 1) * WORDS_PER_NEURON);
            end
        end
    end

    nn_weight_fetch #(
        .ADDR_W(ADDR_W)
    ) u_fetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (fetch_start),
        .start_addr (start_addr),
        .clear      (fetch_clear),
        .wmem_data  (wmem_data),
        .wmem_en    (wmem_en),
        .wmem_addr  (wmem_addr),
        .w_flat     (nw_flat),
        .bias       (nbias),
        .done       (fetch_done)
    );

    // Main FSM with registered stream/status outputs and activation storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_X;
            x_cnt     <= '0;
            n         <= '0;
            // NOTE: the activation slots are reset because they drive nx_flat
            // directly and a reset must also discard a partial frame.
            nx_flat   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD_X: begin
                    if (in_fire) begin
                        nx_flat[{x_cnt, 3'b000} +: DATA_W] <= in_data;
                        x_cnt <= x_cnt + 3'd1;
                        if (x_cnt == 3'd7) begin
                            state    <= FETCH;
                            n        <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (fetch_done) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    out_data  <= nout;
                    out_valid <= 1'b1;
                    out_last  <= last_n;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (last_n) begin
                            state    <= LOAD_X;
                            n        <= '0;
                            x_cnt    <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            n     <= n + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
            endcase
        end
    end

`ifdef NEURON_SEQ_FRAME_CNT_EN
    // Completed-frame counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (out_fire && out_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
